// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register file, bypasses same-cycle write-back,
// and holds one instruction for execute with write-back refresh while stalled.
module operand_fetch_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [AW-1:0]   RS1_ADDR,
    input  logic [AW-1:0]   RS2_ADDR,
    input  logic [AW-1:0]   RD_ADDR_IN,
    input  logic [31:0]     PC_IN,
    output logic [AW-1:0]   RF_ADDR1,
    output logic [AW-1:0]   RF_ADDR2,
    input  logic [XLEN-1:0] RF_DATA1,
    input  logic [XLEN-1:0] RF_DATA2,
    input  logic            WB_WRITE,
    input  logic [AW-1:0]   WB_ADDR,
    input  logic [XLEN-1:0] WB_DATA,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OP1,
    output logic [XLEN-1:0] OP2,
    output logic [AW-1:0]   RD_OUT,
    output logic [31:0]     PC_OUT,
    output logic [AW-1:0]   RS1_OUT,
    output logic [AW-1:0]   RS2_OUT,
    output logic [15:0]     STALL_CNT
);

    // Handshakes: a beat moves when valid && ready on a rising edge. Upstream
    // ready depends only on the output register state, never on FLUSH.
    logic            out_valid_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [AW-1:0]   rd_q, rs1_q, rs2_q;
    logic [31:0]     pc_q;
    logic [15:0]     stall_q;

    logic            accept;
    logic            hold;
    logic            pop;
    logic [XLEN-1:0] op1_fetch, op2_fetch;
    logic            wb_hits_rs1, wb_hits_rs2;

    assign RF_ADDR1 = RS1_ADDR;
    assign RF_ADDR2 = RS2_ADDR;

    assign IN_READY = !out_valid_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY && !FLUSH;
    assign hold     = out_valid_q && !OUT_READY;
    assign pop      = out_valid_q && OUT_READY;

    // x0 always reads zero; a same-cycle write-back wins over the RF read.
    always_comb begin
        op1_fetch = RF_DATA1;
        op2_fetch = RF_DATA2;
        if (RS1_ADDR == '0)
            op1_fetch = '0;
        else if (WB_WRITE && (WB_ADDR == RS1_ADDR))
            op1_fetch = WB_DATA;
        if (RS2_ADDR == '0)
            op2_fetch = '0;
        else if (WB_WRITE && (WB_ADDR == RS2_ADDR))
            op2_fetch = WB_DATA;
    end

    // A held instruction must not miss a write that lands while it waits.
    assign wb_hits_rs1 = WB_WRITE && (WB_ADDR == rs1_q) && (rs1_q != '0);
    assign wb_hits_rs2 = WB_WRITE && (WB_ADDR == rs2_q) && (rs2_q != '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op1_q       <= op1_fetch;
            op2_q       <= op2_fetch;
            rd_q        <= RD_ADDR_IN;
            rs1_q       <= RS1_ADDR;
            rs2_q       <= RS2_ADDR;
            pc_q        <= PC_IN;
        end else begin
            if (FLUSH || pop)
                out_valid_q <= 1'b0;
            if (hold && wb_hits_rs1)
                op1_q <= WB_DATA;
            if (hold && wb_hits_rs2)
                op2_q <= WB_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            stall_q <= '0;
        else if (hold && !FLUSH && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign OUT_VALID = out_valid_q;
    assign OP1       = op1_q;
    assign OP2       = op2_q;
    assign RD_OUT    = rd_q;
    assign PC_OUT    = pc_q;
    assign RS1_OUT   = rs1_q;
    assign RS2_OUT   = rs2_q;
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed vector bench for operand_fetch_stage with a behavioural register file.
module tb_operand_fetch_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            IN_VALID;
    logic            IN_READY;
    logic [AW-1:0]   RS1_ADDR, RS2_ADDR, RD_ADDR_IN;
    logic [31:0]     PC_IN;
    logic [AW-1:0]   RF_ADDR1, RF_ADDR2;
    logic [XLEN-1:0] RF_DATA1, RF_DATA2;
    logic            WB_WRITE;
    logic [AW-1:0]   WB_ADDR;
    logic [XLEN-1:0] WB_DATA;
    logic            FLUSH;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] OP1, OP2;
    logic [AW-1:0]   RD_OUT, RS1_OUT, RS2_OUT;
    logic [31:0]     PC_OUT;
    logic [15:0]     STALL_CNT;

    int n_vec = 0;
    int n_err = 0;

    operand_fetch_stage #(.XLEN(XLEN), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .RD_ADDR_IN(RD_ADDR_IN), .PC_IN(PC_IN),
        .RF_ADDR1(RF_ADDR1), .RF_ADDR2(RF_ADDR2),
        .RF_DATA1(RF_DATA1), .RF_DATA2(RF_DATA2),
        .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OP1(OP1), .OP2(OP2), .RD_OUT(RD_OUT), .PC_OUT(PC_OUT),
        .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT),
        .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Register file model; write-back is the same port as the RF write port.
    logic [XLEN-1:0] rf [32];
    assign RF_DATA1 = rf[RF_ADDR1];
    assign RF_DATA2 = rf[RF_ADDR2];
    always @(posedge CLK) if (WB_WRITE) rf[WB_ADDR] <= WB_DATA;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic        wbw;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        fl, ordy;
        logic        e_rdy, e_vld;
        logic [31:0] e_op1, e_op2;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1, e_rs2;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vt [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        IN_VALID = v.iv; RS1_ADDR = v.rs1; RS2_ADDR = v.rs2; RD_ADDR_IN = v.rd;
        PC_IN = v.pc; WB_WRITE = v.wbw; WB_ADDR = v.wba; WB_DATA = v.wbd;
        FLUSH = v.fl; OUT_READY = v.ordy;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, ".out_valid"}, {31'd0, OUT_VALID}, {31'd0, v.e_vld});
        check({tag, ".op1"}, OP1, v.e_op1);
        check({tag, ".op2"}, OP2, v.e_op2);
        check({tag, ".rd_out"}, {27'd0, RD_OUT}, {27'd0, v.e_rd});
        check({tag, ".pc_out"}, PC_OUT, v.e_pc);
        check({tag, ".rs1_out"}, {27'd0, RS1_OUT}, {27'd0, v.e_rs1});
        check({tag, ".rs2_out"}, {27'd0, RS2_OUT}, {27'd0, v.e_rs2});
        check({tag, ".stall_cnt"}, {16'd0, STALL_CNT}, {16'd0, v.e_stall});
    endtask

    vec_t idle, zero_exp;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[5] = 32'h11; rf[6] = 32'h22; rf[7] = 32'h33; rf[8] = 32'h44;

        //        iv rs1 rs2 rd pc        wbw wba wbd     fl or | rdy vld op1     op2     rd  pc        rs1 rs2 stall
        vt[0]  = '{1, 5, 6, 1,  32'h100, 0, 0, 32'h0,  0, 1,  1, 1, 32'h11, 32'h22, 1,  32'h100, 5, 6, 16'd0};
        vt[1]  = '{1, 5, 7, 2,  32'h104, 1, 5, 32'hAA, 0, 1,  1, 1, 32'hAA, 32'h33, 2,  32'h104, 5, 7, 16'd0};
        vt[2]  = '{1, 0, 8, 3,  32'h108, 1, 0, 32'hFF, 0, 1,  1, 1, 32'h0,  32'h44, 3,  32'h108, 0, 8, 16'd0};
        vt[3]  = '{0, 0, 0, 0,  32'h0,   0, 0, 32'h0,  0, 1,  1, 0, 32'h0,  32'h44, 3,  32'h108, 0, 8, 16'd0};
        vt[4]  = '{0, 0, 0, 0,  32'h0,   1, 8, 32'h77, 0, 1,  1, 0, 32'h0,  32'h44, 3,  32'h108, 0, 8, 16'd0};
        vt[5]  = '{1, 5, 6, 4,  32'h200, 0, 0, 32'h0,  0, 0,  1, 1, 32'hAA, 32'h22, 4,  32'h200, 5, 6, 16'd0};
        vt[6]  = '{1, 7, 8, 5,  32'h204, 0, 0, 32'h0,  0, 0,  0, 1, 32'hAA, 32'h22, 4,  32'h200, 5, 6, 16'd1};
        vt[7]  = '{0, 0, 0, 0,  32'h0,   1, 6, 32'h99, 0, 0,  0, 1, 32'hAA, 32'h99, 4,  32'h200, 5, 6, 16'd2};
        vt[8]  = '{0, 0, 0, 0,  32'h0,   1, 0, 32'h55, 0, 0,  0, 1, 32'hAA, 32'h99, 4,  32'h200, 5, 6, 16'd3};
        vt[9]  = '{0, 0, 0, 0,  32'h0,   0, 0, 32'h0,  0, 1,  1, 0, 32'hAA, 32'h99, 4,  32'h200, 5, 6, 16'd3};
        vt[10] = '{1, 5, 0, 6,  32'h300, 0, 0, 32'h0,  0, 1,  1, 1, 32'hAA, 32'h0,  6,  32'h300, 5, 0, 16'd3};
        vt[11] = '{1, 6, 0, 7,  32'h304, 0, 0, 32'h0,  0, 1,  1, 1, 32'h99, 32'h0,  7,  32'h304, 6, 0, 16'd3};
        vt[12] = '{1, 7, 0, 8,  32'h308, 0, 0, 32'h0,  0, 1,  1, 1, 32'h33, 32'h0,  8,  32'h308, 7, 0, 16'd3};
        vt[13] = '{1, 8, 0, 9,  32'h30C, 0, 0, 32'h0,  0, 1,  1, 1, 32'h77, 32'h0,  9,  32'h30C, 8, 0, 16'd3};
        vt[14] = '{1, 5, 6, 10, 32'h400, 0, 0, 32'h0,  1, 1,  1, 0, 32'h77, 32'h0,  9,  32'h30C, 8, 0, 16'd3};
        vt[15] = '{1, 7, 5, 11, 32'h500, 0, 0, 32'h0,  0, 0,  1, 1, 32'h33, 32'hAA, 11, 32'h500, 7, 5, 16'd3};
        vt[16] = '{0, 0, 0, 0,  32'h0,   0, 0, 32'h0,  1, 0,  0, 0, 32'h33, 32'hAA, 11, 32'h500, 7, 5, 16'd3};
        vt[17] = '{0, 0, 0, 0,  32'h0,   0, 0, 32'h0,  0, 0,  1, 0, 32'h33, 32'hAA, 11, 32'h500, 7, 5, 16'd3};

        idle     = '{0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 16'd0};
        zero_exp = idle;

        // Clock/reset
        RESET = 1'b1;
        drive(idle);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        check("reset.in_ready", {31'd0, IN_READY}, 32'd1);
        check_outs("reset", zero_exp);

        // Table: inputs set after the edge, ready checked combinationally, outputs after next edge
        for (int i = 0; i < 18; i++) begin
            drive(vt[i]);
            #1 check($sformatf("v%0d.in_ready", i), {31'd0, IN_READY}, {31'd0, vt[i].e_rdy});
            check($sformatf("v%0d.rf_addr1", i), {27'd0, RF_ADDR1}, {27'd0, vt[i].rs1});
            check($sformatf("v%0d.rf_addr2", i), {27'd0, RF_ADDR2}, {27'd0, vt[i].rs2});
            @(posedge CLK);
            #1 check_outs($sformatf("v%0d", i), vt[i]);
        end

        // Long stall saturates the counter, then reset mid-hold drops everything
        drive('{1, 5, 6, 12, 32'h600, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge CLK);
        #1 check("sat.accept_valid", {31'd0, OUT_VALID}, 32'd1);
        check("sat.op2", OP2, 32'h99);
        drive('{0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (65540) @(posedge CLK);
        #1 check("sat.stall_cnt", {16'd0, STALL_CNT}, 32'hFFFF);
        check("sat.in_ready", {31'd0, IN_READY}, 32'd0);

        RESET = 1'b1;
        drive('{1, 7, 8, 13, 32'h700, 1, 7, 32'h5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(posedge CLK);
        #1 RESET = 1'b0;
        check_outs("rst_hold", zero_exp);
        drive(idle);
        #1 check("rst_hold.in_ready", {31'd0, IN_READY}, 32'd1);
        repeat (2) begin
            @(posedge CLK);
            #1 check("rst_hold.no_beat", {31'd0, OUT_VALID}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 Parameter XLEN, default 32: register/operand data width.
REQ-002 Parameter AW, default 5: register address width (32 registers).
REQ-003 CLK  input  1: clock; all state updates on rising edge.
REQ-004 RESET  input  1: synchronous, active-high.
REQ-005 IN_VALID  input  1: decode presents an instruction's operand request.
REQ-006 IN_READY  output  1: stage can accept a request this cycle.
REQ-007 RS1_ADDR, RS2_ADDR  input  AW: source register indices.
REQ-008 RD_ADDR_IN  input  AW: destination index, passed through.
REQ-009 PC_IN  input  32: instruction PC, passed through.
REQ-010 RF_ADDR1, RF_ADDR2  output  AW: register-file read addresses, combinationally equal to RS1_ADDR, RS2_ADDR.
REQ-011 RF_DATA1, RF_DATA2  input  XLEN: register-file read data, valid in the same cycle as RF_ADDR1, RF_ADDR2.
REQ-012 WB_WRITE  input  1; WB_ADDR  input  AW; WB_DATA  input  XLEN: write-back port, identical to the register-file write port in the same cycle.
REQ-013 FLUSH  input  1: discard held and incoming instruction.
REQ-014 OUT_VALID  output  1; OUT_READY  input  1: execute-stage handshake.
REQ-015 OP1, OP2  output  XLEN; RD_OUT  output  AW; PC_OUT  output  32: registered operands and pass-through fields.
REQ-016 RS1_OUT, RS2_OUT  output  AW: registered source indices of the held instruction.
REQ-017 STALL_CNT  output  16: count of back-pressure cycles.

Function
REQ-018 IN_READY SHALL equal (!OUT_VALID || OUT_READY), combinationally.
REQ-019 Accept = IN_VALID && IN_READY && !FLUSH; on accept, all output registers SHALL load on the next edge: latency exactly 1 cycle, OUT_VALID=1.
REQ-020 Captured operand n (n=1,2): 0 if RSn_ADDR==0; else WB_DATA if WB_WRITE && WB_ADDR==RSn_ADDR; else RF_DATAn.
REQ-021 OUT_VALID && OUT_READY without accept SHALL clear OUT_VALID next cycle; accept and pop in the same cycle SHALL keep OUT_VALID=1 with new contents (back-to-back, no bubble).
REQ-022 Hold (OUT_VALID && !OUT_READY): RD_OUT, PC_OUT, RSn_OUT SHALL stay stable; OPn SHALL load WB_DATA when WB_WRITE && WB_ADDR==RSn_OUT && RSn_OUT!=0; otherwise stable.
REQ-023 Write-back to register 0 SHALL never alter OP1/OP2.
REQ-024 FLUSH SHALL clear OUT_VALID next cycle and discard any concurrent IN_VALID beat; IN_READY is unaffected by FLUSH.
REQ-025 With OUT_VALID=0 and no accept, data outputs SHALL retain previous values.
REQ-026 STALL_CNT SHALL increment by 1 each cycle OUT_VALID && !OUT_READY && !FLUSH, saturating at 0xFFFF.

Reset
REQ-027 RESET SHALL have priority over FLUSH and accept.
REQ-028 On RESET: OUT_VALID=0, OP1=OP2=0, RD_OUT=0, RSn_OUT=0, PC_OUT=0, STALL_CNT=0; IN_READY=1 the cycle after.
REQ-029 RESET mid-hold SHALL drop the held instruction; no output beat afterwards until a new accept.

Verification
REQ-030 RF holds x5=0x11, x6=0x22; request RS1=5, RS2=6, PC=0x100, OUT_READY=1 -> next cycle OUT_VALID=1, OP1=0x11, OP2=0x22, PC_OUT=0x100.
REQ-031 Same-cycle WB_WRITE=1, WB_ADDR=5, WB_DATA=0xAA with request RS1=5 -> OP1=0xAA (bypass).
REQ-032 Request RS1=0 with WB_WRITE to x0 data 0xFF -> OP1=0.
REQ-033 Hold with OUT_READY=0 for 3 cycles, WB writes x6=0x99 in cycle 2 -> OP2=0x99 afterwards, IN_READY=0 throughout, STALL_CNT=3.
REQ-034 Continuous IN_VALID=1 and OUT_READY=1 for 4 requests -> 4 consecutive OUT_VALID cycles, no bubble, in order.
REQ-035 FLUSH=1 with OUT_VALID=1 and IN_VALID=1 -> next cycle OUT_VALID=0, incoming beat never appears; RESET asserted during hold -> all outputs 0.
